out_port_tx: RTL and testbench

OUT_PORT_TX -- requirements
Module: out_port_tx

---
 rtl/out_port_tx_if.sv | 14 +
 rtl/out_port_tx.sv | 121 ++++++++++++
 tb/tb_out_port_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/out_port_tx_if.sv
// out_port_tx_if: CPU-side write port and serial/status outputs of out_port_tx.
interface out_port_tx_if;
   logic       wr_stb;
   logic [7:0] din;
   logic       ovf_clr;
   logic       tx;
   logic       busy;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       ovf;
   modport master (output wr_stb, din, ovf_clr, input tx, busy, count, full, empty, ovf);
   modport slave  (input wr_stb, din, ovf_clr, output tx, busy, count, full, empty, ovf);
endinterface

// File: rtl/out_port_tx.sv
// out_port_tx: 4-deep byte FIFO feeding an 8N1 serial transmitter, CLK_DIV clocks per bit.
// Define OUT_PORT_TX_PARITY_EN to insert an even-parity bit between data and stop.
module out_port_tx #(
   parameter int CLK_DIV = 4
) (
   input logic        clk,
   input logic        rst,
   out_port_tx_if.slave bus
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef OUT_PORT_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [7:0] W_DIV  = 8'(CLK_DIV - 1);

   logic [7:0] r_mem [4];
   logic [1:0] r_wp, r_rp;
   logic [2:0] r_count, r_state, r_bit;
   logic [7:0] r_sh, r_bcnt;
   logic       r_tx, r_ovf;
`ifdef OUT_PORT_TX_PARITY_EN
   logic       r_par;
`endif
   logic       w_empty, w_full, w_tick, w_pop, w_push, w_drop;
   logic [7:0] w_bnext;

   assign w_empty = r_count == 3'd0;
   assign w_full  = r_count == 3'd4;
   assign w_tick  = r_bcnt == 8'd0;
   assign w_bnext = w_tick ? W_DIV : r_bcnt - 8'd1;
   // A pop happens from IDLE, or on the last STOP clock for a gapless next frame
   assign w_pop   = !w_empty && (r_state == IDLE || (r_state == STOP && w_tick));
   assign w_push  = bus.wr_stb && (!w_full || w_pop);
   assign w_drop  = bus.wr_stb && w_full && !w_pop;

   assign bus.tx    = r_tx;
   assign bus.busy  = r_state != IDLE;
   assign bus.count = r_count;
   assign bus.full  = w_full;
   assign bus.empty = w_empty;
   assign bus.ovf   = r_ovf;

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= bus.din;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_wp    <= w_push ? r_wp + 2'd1 : r_wp;
         r_rp    <= w_pop ? r_rp + 2'd1 : r_rp;
         r_count <= r_count + 3'(w_push) - 3'(w_pop);
         r_ovf   <= w_drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : r_ovf);
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_tx    <= 1'b1;
         r_bcnt  <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
`ifdef OUT_PORT_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (w_pop) begin
         r_state <= START;
         r_tx    <= 1'b0;
         r_bcnt  <= W_DIV;
         r_sh    <= r_mem[r_rp];
`ifdef OUT_PORT_TX_PARITY_EN
         r_par   <= ^r_mem[r_rp];
`endif
      end else begin
         r_bcnt <= (r_state == IDLE) ? r_bcnt : w_bnext;
         case (r_state)
            START:
               if (w_tick) begin
                  r_state <= DATA;
                  r_bit   <= '0;
                  r_tx    <= r_sh[0];
               end
            DATA:
               if (w_tick && r_bit == 3'd7) begin
`ifdef OUT_PORT_TX_PARITY_EN
                  r_state <= PARITY;
                  r_tx    <= r_par;
`else
                  r_state <= STOP;
                  r_tx    <= 1'b1;
`endif
               end else if (w_tick) begin
                  r_bit <= r_bit + 3'd1;
                  r_sh  <= r_sh >> 1;
                  r_tx  <= r_sh[1];
               end
`ifdef OUT_PORT_TX_PARITY_EN
            PARITY:
               if (w_tick) begin
                  r_state <= STOP;
                  r_tx    <= 1'b1;
               end
`endif
            STOP:
               if (w_tick) begin
                  r_state <= IDLE;
                  r_tx    <= 1'b1;
               end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
endmodule

// File: tb/tb_out_port_tx.sv
// tb_out_port_tx: directed table-driven frame checks plus overflow, back-to-back and reset sequences.
module tb_out_port_tx;
   localparam int D = 4;
`ifdef OUT_PORT_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   out_port_tx_if bus();
   out_port_tx #(.CLK_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // bits: {stop, d7..d0, start}, i.e. bit k is the k-th serial bit without parity
   typedef struct {
      logic [7:0] din;
      logic [9:0] bits;
      logic       par;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] b);
      @(negedge clk);
      bus.wr_stb = 1'b1;
      bus.din    = b;
      @(negedge clk);
      bus.wr_stb = 1'b0;
   endtask

   // Called at the first START cycle; checks tx and busy on every clock of the frame
   task automatic frame(input string name, input logic [9:0] bits, input logic par);
      logic [10:0] seq;
      int bad;
      bad = 0;
      seq = {bits[9], par, bits[8:0]};
`ifndef OUT_PORT_TX_PARITY_EN
      seq[10:9] = {1'b0, bits[9]};
`endif
      for (int k = 0; k < NB; k++)
         for (int c = 0; c < D; c++) begin
            if (bus.tx !== seq[k] || bus.busy !== 1'b1) bad++;
            @(negedge clk);
         end
      chk(name, bad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int bad;
      bus.wr_stb  = 1'b0;
      bus.din     = 8'h00;
      bus.ovf_clr = 1'b0;
      vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
      vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
      vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
      vecs[3] = '{8'h07, 10'b1000001110, 1'b1};
      vecs[4] = '{8'h03, 10'b1000000110, 1'b0};
      vecs[5] = '{8'h5A, 10'b1010110100, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst tx", bus.tx, 1);
      chk("rst busy", bus.busy, 0);
      chk("rst count", bus.count, 0);
      chk("rst empty", bus.empty, 1);
      chk("rst full", bus.full, 0);
      chk("rst ovf", bus.ovf, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         wr(vecs[i].din);
         chk($sformatf("vec%0d count", i), bus.count, 1);
         @(negedge clk);
         chk($sformatf("vec%0d empty", i), bus.empty, 1);
         frame($sformatf("vec%0d frame", i), vecs[i].bits, vecs[i].par);
         chk($sformatf("vec%0d idle busy", i), bus.busy, 0);
         chk($sformatf("vec%0d idle tx", i), bus.tx, 1);
      end

      // back-to-back: second frame must start on the clock after the first stop
      @(negedge clk);
      bus.wr_stb = 1'b1;
      bus.din    = 8'h00;
      @(negedge clk);
      bus.din    = 8'hFF;
      @(negedge clk);
      bus.wr_stb = 1'b0;
      chk("b2b count", bus.count, 1);
      frame("b2b frame1", 10'b1000000000, 1'b0);
      frame("b2b frame2", 10'b1111111110, 1'b0);
      chk("b2b end busy", bus.busy, 0);

      // overflow: six strobes, the sixth is dropped
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            chk("ovf5 count", bus.count, 4);
            chk("ovf5 full", bus.full, 1);
            chk("ovf5 ovf", bus.ovf, 0);
         end
         bus.wr_stb = 1'b1;
         bus.din    = 8'(8'h11 + i);
      end
      @(negedge clk);
      bus.wr_stb = 1'b0;
      chk("ovf6 count", bus.count, 4);
      chk("ovf6 full", bus.full, 1);
      chk("ovf6 ovf", bus.ovf, 1);
      repeat (NB * D - 4) @(negedge clk);
      frame("ovf frame 12", 10'b1000100100, 1'b0);
      frame("ovf frame 13", 10'b1000100110, 1'b1);
      frame("ovf frame 14", 10'b1000101000, 1'b0);
      frame("ovf frame 15", 10'b1000101010, 1'b1);
      chk("ovf end busy", bus.busy, 0);
      chk("ovf end count", bus.count, 0);
      chk("ovf sticky", bus.ovf, 1);
      @(negedge clk);
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      chk("ovf cleared", bus.ovf, 0);

      // clear race: a drop in the same cycle as ovf_clr keeps ovf set
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.wr_stb = 1'b1;
         bus.din    = 8'(8'h21 + i);
      end
      @(negedge clk);
      chk("race pre ovf", bus.ovf, 1);
      bus.din     = 8'h27;
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.wr_stb = 1'b0;
      chk("race ovf kept", bus.ovf, 1);
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      chk("race ovf clr", bus.ovf, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // reset during DATA bit 3 with two bytes queued
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.wr_stb = 1'b1;
         bus.din    = (i == 0) ? 8'hF7 : 8'(i);
      end
      @(negedge clk);
      bus.wr_stb = 1'b0;
      repeat (4 * D) @(negedge clk);
      chk("mid busy", bus.busy, 1);
      chk("mid count", bus.count, 2);
      chk("mid tx bit3", bus.tx, 0);
      rst = 1'b1;
      #1;
      chk("mid rst tx", bus.tx, 1);
      chk("mid rst count", bus.count, 0);
      chk("mid rst busy", bus.busy, 0);
      chk("mid rst empty", bus.empty, 1);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (12 * D) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 3'd0) bad++;
      end
      chk("post rst quiet", bad, 0);

      // a write on the first edge after reset release is kept
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      bus.wr_stb = 1'b1;
      bus.din    = 8'h3C;
      @(negedge clk);
      bus.wr_stb = 1'b0;
      chk("rel count", bus.count, 1);
      @(negedge clk);
      frame("rel frame", 10'b1001111000, 1'b0);
      chk("rel end busy", bus.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
